noise_floor_cfar_ctrl: RTL

//  Frame-level sequencer for the noise-floor power estimator: clears it, trains it over N leading bins, then

---
 rtl/noise_floor_cfar_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/noise_floor_cfar_ctrl.sv
// noise_floor_cfar_ctrl: frame sequencer for an external noise-floor power
// estimator. Each frame clears the estimator and trains it on the first N bins.
// It then compares every following bin's power metric against a scaled and
// offset copy of the estimator threshold, and flags the bins that exceed it.
module noise_floor_cfar_ctrl #(
  parameter int N       = 16,
  parameter int BINS    = 512,
  parameter int EST_LAT = 1,
  parameter int DATA_W  = 16,
  localparam int CNT_W  = $clog2(BINS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cfg_shift,
  input  logic [DATA_W-1:0] cfg_offset,
  input  logic              cfg_track,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              est_clr,
  output logic              est_ce,
  output logic [DATA_W-1:0] est_d,
  input  logic [DATA_W-1:0] est_thr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_det,
  output logic [CNT_W-1:0]  m_index,
  output logic [DATA_W-1:0] m_metric,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [CNT_W-1:0]  det_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_TRAIN  = 3'd2;
  localparam logic [2:0] S_ARM    = 3'd3;
  localparam logic [2:0] S_DETECT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int ARM_W = (EST_LAT > 1) ? $clog2(EST_LAT) : 1;
  localparam logic [DATA_W-1:0] P_BIAS = {1'b1, {(DATA_W-1){1'b0}}};

  // Power metric used by the estimator: most negative sample maps to 0,
  // most positive to 1, computed modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] metric_of(input logic signed [DATA_W-1:0] d);
    return P_BIAS - $unsigned(d);
  endfunction

  // Effective threshold: (thr << sh) + off, saturated to the metric range.
  // Four guard bits hold the full sum so the clamp never sees a wrapped value.
  function automatic logic [DATA_W-1:0] thr_sat(input logic [DATA_W-1:0] thr,
                                                input logic [1:0]        sh,
                                                input logic [DATA_W-1:0] off);
    logic [DATA_W+3:0] acc;
    acc = ({4'b0000, thr} << sh) + {4'b0000, off};
    if (acc[DATA_W+3:DATA_W] != 4'b0000) return {DATA_W{1'b1}};
    return acc[DATA_W-1:0];
  endfunction

  logic [2:0]              state_q, state_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic [ARM_W-1:0]        arm_q, arm_d;
  logic                    err_q, err_d;
  logic [1:0]              shift_q;
  logic [DATA_W-1:0]       offset_q;
  logic                    track_q;
  logic [CNT_W-1:0]        det_cnt_q;
  logic                    m_valid_q;
  logic                    m_det_q;
  logic [CNT_W-1:0]        m_index_q;
  logic [DATA_W-1:0]       m_metric_q;
  logic                    est_ce_q;
  logic [DATA_W-1:0]       est_d_q;

  logic signed [DATA_W-1:0] s_data_s;
  logic [DATA_W-1:0]        p_now;
  logic [DATA_W-1:0]        thr_eff;
  logic                     det_now;
  logic                     in_train, in_detect;
  logic                     beat, out_acc, feed_est, start_acc;

  assign s_data_s  = s_data;
  assign p_now     = metric_of(s_data_s);
  assign thr_eff   = thr_sat(est_thr, shift_q, offset_q);
  assign det_now   = p_now > thr_eff;

  assign in_train  = (state_q == S_TRAIN);
  assign in_detect = (state_q == S_DETECT);
  assign s_ready   = in_train | (in_detect & (~m_valid_q | m_ready));
  assign beat      = s_valid & s_ready;
  assign out_acc   = m_valid_q & m_ready;
  assign feed_est  = beat & (in_train | (in_detect & track_q));
  assign start_acc = (state_q == S_IDLE) & start;

  assign est_clr    = (state_q == S_CLR);
  assign est_ce     = est_ce_q;
  assign est_d      = est_d_q;
  assign m_valid    = m_valid_q;
  assign m_det      = m_det_q;
  assign m_index    = m_index_q;
  assign m_metric   = m_metric_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE) & ~m_valid_q;
  assign frame_err  = frame_done & err_q;
  assign det_cnt    = det_cnt_q;

  // Frame sequencing: next state, bin index, arm delay and error flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    arm_d   = arm_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_CLR: state_d = S_TRAIN;
      S_TRAIN: begin
        if (beat) begin
          idx_d = idx_q + 1'b1;
          if (s_last) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (idx_q == CNT_W'(N - 1)) begin
            state_d = S_ARM;
            arm_d   = '0;
          end
        end
      end
      S_ARM: begin
        if (arm_q == ARM_W'(EST_LAT - 1)) state_d = S_DETECT;
        else                              arm_d   = arm_q + 1'b1;
      end
      S_DETECT: begin
        if (beat) begin
          idx_d = idx_q + 1'b1;
          if (s_last) begin
            state_d = S_DONE;
          end else if (idx_q == CNT_W'(BINS - 1)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!m_valid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers: FSM, per-frame configuration and detection counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      arm_q     <= '0;
      err_q     <= 1'b0;
      shift_q   <= '0;
      offset_q  <= '0;
      track_q   <= 1'b0;
      det_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      arm_q   <= arm_d;
      err_q   <= err_d;
      if (start_acc) begin
        shift_q   <= cfg_shift;
        offset_q  <= cfg_offset;
        track_q   <= cfg_track;
        det_cnt_q <= '0;
      end else if (out_acc && m_det_q && (det_cnt_q != {CNT_W{1'b1}})) begin
        det_cnt_q <= det_cnt_q + 1'b1;
      end
    end
  end

  // Estimator feed: registered sample plus step enable one cycle after the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      est_ce_q <= 1'b0;
      est_d_q  <= '0;
    end else begin
      est_ce_q <= feed_est;
      if (feed_est) est_d_q <= s_data;
    end
  end

  // Single result register: loads on a detect beat, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q  <= 1'b0;
      m_det_q    <= 1'b0;
      m_index_q  <= '0;
      m_metric_q <= '0;
    end else if (beat && in_detect) begin
      m_valid_q  <= 1'b1;
      m_det_q    <= det_now;
      m_index_q  <= idx_q;
      m_metric_q <= p_now;
    end else if (m_ready) begin
      m_valid_q  <= 1'b0;
    end
  end

endmodule
